// File: rtl/tmr_scrub_ctrl.sv
// Clock-gate enable scheduler for triplicated register banks. It merges functional
// gate requests, voter-error refreshes and periodic background scrubs into per-bank enables.
module tmr_scrub_ctrl #(
    parameter int unsigned N_BANKS      = 4,
    parameter int unsigned SCRUB_PERIOD = 1024,
    parameter int unsigned HOLD         = 2,
    parameter int unsigned CNT_W        = 16,
    localparam int unsigned BANK_W      = $clog2(N_BANKS)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_BANKS-1:0] err_i,
    input  logic [N_BANKS-1:0] gate_req_i,
    input  logic               scrub_en_i,
    input  logic               err_clr_i,
    output logic [N_BANKS-1:0] gate_o,
    output logic               busy_o,
    output logic [BANK_W-1:0]  bank_o,
    output logic [N_BANKS-1:0] err_flag_o,
    output logic [CNT_W-1:0]   err_cnt_o
);
    localparam int unsigned PER_W  = $clog2(SCRUB_PERIOD);
    localparam int unsigned HOLD_W = $clog2(HOLD + 1);
    localparam int unsigned EDGE_W = $clog2(N_BANKS + 1);
    localparam int unsigned SUM_W  = CNT_W + EDGE_W;
    localparam int unsigned IDX_W  = BANK_W + 1;

    typedef enum logic [1:0] {IDLE, ARB, REFRESH} state_t;

    state_t              state;
    logic [N_BANKS-1:0]  err_q;
    logic [N_BANKS-1:0]  pending;
    logic [N_BANKS-1:0]  pending_d;
    logic [N_BANKS-1:0]  edges;
    logic [N_BANKS-1:0]  refresh_mask;
    logic [N_BANKS-1:0]  clr_mask;
    logic [N_BANKS-1:0]  flag_d;
    logic [BANK_W-1:0]   ptr;
    logic [BANK_W-1:0]   target;
    logic [BANK_W-1:0]   pick;
    logic [IDX_W-1:0]    idx;
    logic                found;
    logic [PER_W-1:0]    per_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                per_hit;
    logic                refresh_done;
    logic [EDGE_W-1:0]   n_edges;
    logic [CNT_W-1:0]    cnt_base;
    logic [SUM_W-1:0]    cnt_sum;
    logic [CNT_W-1:0]    cnt_d;

    // A bank high in the first cycle after reset counts as a fresh error because err_q resets low.
    assign edges        = err_i & ~err_q;
    assign per_hit      = scrub_en_i && (state == IDLE) && (per_cnt == PER_W'(SCRUB_PERIOD - 1));
    assign refresh_done = (state == REFRESH) && (hold_cnt == HOLD_W'(HOLD - 1));

    // A new edge on the target bank wins over the clear applied on refresh exit.
    assign pending_d = (pending & ~clr_mask) | edges;
    assign flag_d    = (err_clr_i ? '0 : err_flag_o) | edges;
    assign cnt_base  = err_clr_i ? '0 : err_cnt_o;
    assign cnt_sum   = SUM_W'(cnt_base) + SUM_W'(n_edges);
    assign cnt_d     = (cnt_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : CNT_W'(cnt_sum);

    always_comb begin
        refresh_mask = '0;
        clr_mask     = '0;
        n_edges      = '0;
        for (int i = 0; i < int'(N_BANKS); i++) begin
            refresh_mask[i] = (state == REFRESH) && (target == BANK_W'(i));
            clr_mask[i]     = refresh_done && (target == BANK_W'(i));
            n_edges         = n_edges + EDGE_W'(edges[i]);
        end
    end

    // Round-robin search: first pending bank at or after the pointer.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < int'(N_BANKS); k++) begin
            idx = IDX_W'(ptr) + IDX_W'(k);
            if (idx >= IDX_W'(N_BANKS)) begin
                idx = idx - IDX_W'(N_BANKS);
            end
            if (!found && pending[idx[BANK_W-1:0]]) begin
                pick  = idx[BANK_W-1:0];
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q      <= '0;
            pending    <= '0;
            err_flag_o <= '0;
            err_cnt_o  <= '0;
        end else begin
            err_q      <= err_i;
            pending    <= pending_d;
            err_flag_o <= flag_d;
            err_cnt_o  <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            ptr      <= '0;
            target   <= '0;
            hold_cnt <= '0;
            per_cnt  <= '0;
            gate_o   <= '0;
            busy_o   <= 1'b0;
            bank_o   <= '0;
        end else begin
            gate_o <= gate_req_i | refresh_mask;
            busy_o <= (state == REFRESH);
            if (state == REFRESH) begin
                bank_o <= target;
            end

            // Scrub interval only advances while no refresh is in flight.
            if (!scrub_en_i) begin
                per_cnt <= '0;
            end else if (state == IDLE) begin
                per_cnt <= per_hit ? '0 : per_cnt + PER_W'(1);
            end

            case (state)
                IDLE: begin
                    if (|pending) begin
                        state <= ARB;
                    end else if (per_hit) begin
                        target   <= ptr;
                        hold_cnt <= '0;
                        state    <= REFRESH;
                    end
                end
                ARB: begin
                    target   <= pick;
                    hold_cnt <= '0;
                    state    <= REFRESH;
                end
                REFRESH: begin
                    if (refresh_done) begin
                        state <= IDLE;
                        ptr   <= (target == BANK_W'(N_BANKS - 1)) ? '0 : target + BANK_W'(1);
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Directed bench for tmr_scrub_ctrl: refresh events are queued as expected when stimulus
// is driven and matched by a monitor when busy_o rises.
module tb_tmr_scrub_ctrl;
    localparam int unsigned NB   = 4;
    localparam int unsigned SP   = 1024;
    localparam int unsigned HOLD = 2;
    localparam int unsigned CW   = 4;
    localparam int unsigned BW   = $clog2(NB);

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [NB-1:0] err_i = '0;
    logic [NB-1:0] gate_req_i = '0;
    logic          scrub_en_i = 1'b0;
    logic          err_clr_i = 1'b0;
    logic [NB-1:0] gate_o;
    logic          busy_o;
    logic [BW-1:0] bank_o;
    logic [NB-1:0] err_flag_o;
    logic [CW-1:0] err_cnt_o;

    tmr_scrub_ctrl #(
        .N_BANKS(NB), .SCRUB_PERIOD(SP), .HOLD(HOLD), .CNT_W(CW)
    ) dut (
        .clk(clk), .rstn(rstn), .err_i(err_i), .gate_req_i(gate_req_i),
        .scrub_en_i(scrub_en_i), .err_clr_i(err_clr_i), .gate_o(gate_o),
        .busy_o(busy_o), .bank_o(bank_o), .err_flag_o(err_flag_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bank;
        int start;
    } ev_t;

    ev_t           sb[$];
    ev_t           ev;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [NB-1:0] req_s = '0;
    logic [NB-1:0] exp_gate;
    logic          busy_prev = 1'b0;
    int            width = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        req_s <= gate_req_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_refresh(input int bank, input int start);
        sb.push_back('{bank: bank, start: start});
    endtask

    // Refresh monitor: each busy_o rise must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rstn) begin
            busy_prev = 1'b0;
            width     = 0;
        end else begin
            if (busy_o && !busy_prev) begin
                chk("refresh_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    ev       = sb.pop_front();
                    exp_gate = (NB'(1) << ev.bank) | req_s;
                    chk("refresh_bank", 32'(bank_o), 32'(ev.bank));
                    chk("refresh_start", 32'(cyc), 32'(ev.start));
                    chk("refresh_gate", 32'(gate_o), 32'(exp_gate));
                end
                width = 1;
            end else if (busy_o) begin
                width++;
            end
            if (!busy_o && busy_prev) begin
                chk("refresh_width", 32'(width), 32'(HOLD));
                chk("gate_after_refresh", 32'(gate_o), 32'(req_s));
            end
            busy_prev = busy_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        #1 rstn = 1'b0;
        tick(3);
        chk("rst_gate", 32'(gate_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_bank", 32'(bank_o), 32'd0);
        chk("rst_flag", 32'(err_flag_o), 32'd0);
        chk("rst_cnt", 32'(err_cnt_o), 32'd0);
        rstn = 1'b1;

        // Idle with scrubbing off: nothing may fire.
        for (int i = 0; i < 5000; i++) begin
            tick(1);
            chk("idle_quiet", 32'({gate_o, busy_o, err_flag_o, err_cnt_o}), 32'd0);
        end

        // Functional request passes with one cycle latency.
        gate_req_i = 4'b1010;
        chk("req_not_yet", 32'(gate_o), 32'd0);
        tick(1);
        chk("req_latency", 32'(gate_o), 32'b1010);
        gate_req_i = '0;
        tick(1);
        chk("req_release", 32'(gate_o), 32'd0);

        // Periodic scrub: banks 0,1,2,3,0; counter pauses during each HOLD-cycle refresh.
        tick(1);
        c = cyc;
        scrub_en_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_refresh(k % int'(NB), c + int'(SP) + 1 + k * int'(SP + HOLD));
        end
        tick(5140);
        scrub_en_i = 1'b0;
        chk("scrub_all_seen", 32'(sb.size()), 32'd0);

        // err_i[2] pulse for 5 cycles, functional request on bank 0 stays visible.
        gate_req_i = 4'b0001;
        tick(2);
        c = cyc;
        err_i = 4'b0100;
        expect_refresh(2, c + 4);
        tick(5);
        err_i = '0;
        tick(6);
        chk("err2_cnt", 32'(err_cnt_o), 32'd1);
        chk("err2_flag", 32'(err_flag_o), 32'b0100);
        chk("err2_gate_req", 32'(gate_o), 32'b0001);
        gate_req_i = '0;
        tick(1);

        // Single edge on bank 1; search wraps from pointer 3.
        c = cyc;
        err_i = 4'b0010;
        expect_refresh(1, c + 4);
        tick(1);
        err_i = '0;
        tick(8);
        chk("err1_cnt", 32'(err_cnt_o), 32'd2);
        chk("err1_flag", 32'(err_flag_o), 32'b0110);

        // Simultaneous edges on banks 1 and 3 with pointer at 2.
        c = cyc;
        err_i = 4'b1010;
        expect_refresh(3, c + 4);
        expect_refresh(1, c + 8);
        tick(1);
        err_i = '0;
        tick(12);
        chk("dual_cnt", 32'(err_cnt_o), 32'd4);
        chk("dual_flag", 32'(err_flag_o), 32'b1110);
        chk("dual_done", 32'(sb.size()), 32'd0);

        // Pointer must be back at 2: bank 2 is served before bank 1.
        c = cyc;
        err_i = 4'b0110;
        expect_refresh(2, c + 4);
        expect_refresh(1, c + 8);
        tick(1);
        err_i = '0;
        tick(12);
        chk("ptr_cnt", 32'(err_cnt_o), 32'd6);

        c = cyc;
        err_i = 4'b0001;
        expect_refresh(0, c + 4);
        tick(1);
        err_i = '0;
        tick(8);
        chk("pre_clr_cnt", 32'(err_cnt_o), 32'd7);
        chk("pre_clr_flag", 32'(err_flag_o), 32'b1111);

        // Clear coincident with a new edge on bank 0.
        c = cyc;
        err_i = 4'b0001;
        err_clr_i = 1'b1;
        expect_refresh(0, c + 4);
        tick(1);
        err_clr_i = 1'b0;
        err_i = '0;
        chk("clr_cnt", 32'(err_cnt_o), 32'd1);
        chk("clr_flag", 32'(err_flag_o), 32'b0001);
        tick(8);

        // Twenty more edges saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            c = cyc;
            err_i = NB'(1) << (i % int'(NB));
            expect_refresh(i % int'(NB), c + 4);
            tick(1);
            err_i = '0;
            tick(8);
            if (i == 9) chk("sat_mid_cnt", 32'(err_cnt_o), 32'd11);
        end
        chk("sat_cnt", 32'(err_cnt_o), 32'd15);
        chk("sat_done", 32'(sb.size()), 32'd0);

        // Reset in the middle of a refresh, with bank 2 still pending.
        c = cyc;
        err_i = 4'b0101;
        expect_refresh(0, c + 4);
        tick(1);
        err_i = '0;
        tick(3);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_gate", 32'(gate_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_cnt", 32'(err_cnt_o), 32'd0);
        chk("midrst_flag", 32'(err_flag_o), 32'd0);
        tick(3);
        rstn = 1'b1;
        tick(30);
        chk("post_rst_gate", 32'(gate_o), 32'd0);
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        chk("post_rst_queue", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
